// File: rtl/alu_seq_core_if.sv
// Handshake bundle between decode, the sequential ALU core and writeback.
// The master side issues ops and accepts results; the slave side is the core.
interface alu_seq_core_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags, busy
  );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle logic/arith/shift/extend ops plus iterative
// multiply and restoring divide, with a persistent NZCV flag register.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_core_if.slave bus
);

  localparam logic [4:0] OP_ANDS = 5'd1,  OP_ORRS = 5'd2,  OP_MVNS = 5'd3,  OP_EORS = 5'd4;
  localparam logic [4:0] OP_ADCS = 5'd5,  OP_ADDS = 5'd6,  OP_SBCS = 5'd7,  OP_SUB  = 5'd8;
  localparam logic [4:0] OP_MULS = 5'd9,  OP_LSRS = 5'd10, OP_LSLS = 5'd11, OP_ASR  = 5'd12;
  localparam logic [4:0] OP_ROR  = 5'd13, OP_UXTB = 5'd14, OP_UXTH = 5'd15, OP_SXTB = 5'd16;
  localparam logic [4:0] OP_SXTH = 5'd17, OP_CMP  = 5'd18, OP_UDIV = 5'd19, OP_UREM = 5'd20;

  localparam int FN = 0, FZ = 1, FC = 2, FV = 3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [4:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic             in_ready, out_valid, busy;
  logic             accept, iter_op;

  logic [SHW-1:0]   amt, neg_amt;
  logic             cin_add, cin_sub, c_n, v_n, set_nz;
  logic [WIDTH:0]   add_w, sub_w, lsl_w, lsr_w, asr_w;
  logic [WIDTH-1:0] ror_v, val, alu_res;
  logic [3:0]       alu_flags;

  logic [WIDTH-1:0] mul_acc_d, div_rem_d, div_quo_d, iter_res;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;

  assign accept  = bus.in_valid & in_ready;
  assign iter_op = (bus.op == OP_MULS) | (bus.op == OP_UDIV) | (bus.op == OP_UREM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = iter_op ? S_EXEC : S_DONE;
      S_EXEC: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) state_d = iter_op ? S_EXEC : S_DONE;
          else              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_EXEC);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  // Single-cycle datapath. Shifts carry one guard bit so the last bit shifted
  // out falls into a fixed position; amount 0 leaves C untouched.
  always_comb begin
    amt     = bus.b[SHW-1:0];
    neg_amt = SHW'(0) - amt;
    cin_add = (bus.op == OP_ADCS) & flags_q[FC];
    cin_sub = (bus.op == OP_SBCS) ? flags_q[FC] : 1'b1;
    add_w   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin_add};
    sub_w   = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, cin_sub};
    lsl_w   = {1'b0, bus.a} << amt;
    lsr_w   = {bus.a, 1'b0} >> amt;
    asr_w   = $signed({bus.a, 1'b0}) >>> amt;
    ror_v   = (bus.a >> amt) | (bus.a << neg_amt);
    val     = '0;
    c_n     = flags_q[FC];
    v_n     = flags_q[FV];
    set_nz  = 1'b1;
    case (bus.op)
      OP_ANDS: val = bus.a & bus.b;
      OP_ORRS: val = bus.a | bus.b;
      OP_MVNS: val = ~bus.a;
      OP_EORS: val = bus.a ^ bus.b;
      OP_ADCS, OP_ADDS: begin
        val = add_w[WIDTH-1:0];
        c_n = add_w[WIDTH];
        v_n = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (val[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SBCS, OP_SUB, OP_CMP: begin
        val = sub_w[WIDTH-1:0];
        c_n = sub_w[WIDTH];
        v_n = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (val[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_LSLS: begin
        val = lsl_w[WIDTH-1:0];
        if (amt != '0) c_n = lsl_w[WIDTH];
      end
      OP_LSRS: begin
        val = lsr_w[WIDTH:1];
        if (amt != '0) c_n = lsr_w[0];
      end
      OP_ASR: begin
        val = asr_w[WIDTH:1];
        if (amt != '0) c_n = asr_w[0];
      end
      OP_ROR: begin
        val = ror_v;
        if (amt != '0) c_n = ror_v[WIDTH-1];
      end
      OP_UXTB: begin val = {{(WIDTH-8){1'b0}}, bus.a[7:0]};          set_nz = 1'b0; end
      OP_UXTH: begin val = {{(WIDTH-16){1'b0}}, bus.a[15:0]};        set_nz = 1'b0; end
      OP_SXTB: begin val = {{(WIDTH-8){bus.a[7]}}, bus.a[7:0]};      set_nz = 1'b0; end
      OP_SXTH: begin val = {{(WIDTH-16){bus.a[15]}}, bus.a[15:0]};   set_nz = 1'b0; end
      default: set_nz = 1'b0;
    endcase
    alu_flags = {v_n, c_n,
                 set_nz ? (val == '0)     : flags_q[FZ],
                 set_nz ? val[WIDTH-1]    : flags_q[FN]};
    alu_res   = (bus.op == OP_CMP) ? '0 : val;
  end

  // One iteration step: shift-add for MULS, restoring subtract for UDIV/UREM.
  // A zero divisor always "fits", which yields all-ones quotient and remainder a.
  always_comb begin
    mul_acc_d = acc_q + (opb_q[0] ? opa_q : '0);
    div_trial = {acc_q, opa_q[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opb_q});
    div_rem_d = div_ge ? (div_trial[WIDTH-1:0] - opb_q) : div_trial[WIDTH-1:0];
    div_quo_d = {opa_q[WIDTH-2:0], div_ge};
    case (op_q)
      OP_MULS: iter_res = mul_acc_d;
      OP_UDIV: iter_res = div_quo_d;
      default: iter_res = div_rem_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      cnt_q <= SHW'(WIDTH - 1);
      if (iter_op) begin
        acc_q <= '0;
        opa_q <= bus.a;
        opb_q <= bus.b;
      end else begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end
    end else if (state_q == S_EXEC) begin
      cnt_q <= cnt_q - SHW'(1);
      if (op_q == OP_MULS) begin
        acc_q <= mul_acc_d;
        opa_q <= opa_q << 1;
        opb_q <= opb_q >> 1;
      end else begin
        acc_q <= div_rem_d;
        opa_q <= div_quo_d;
      end
      if (cnt_q == '0) begin
        result_q <= iter_res;
        flags_q  <= {(op_q == OP_MULS) ? flags_q[FV] : (opb_q == '0),
                     flags_q[FC], (iter_res == '0), iter_res[WIDTH-1]};
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised and directed bench for alu_seq_core, checked every cycle against
// an arithmetic reference model and a queue of in-flight operations.
module tb_alu_seq_core;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_core_if #(.WIDTH(W)) bus();
  alu_seq_core #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [4:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    int          acc;
    bit          lit;
    logic [31:0] lr;
    logic [3:0]  lf;
  } txn_t;

  txn_t       q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_txn = 0;
  int         ready_mode = 0;
  logic [3:0] mflags = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: flags are {V,C,Z,N}; lat is cycles from accept to out_valid.
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] fi, output logic [31:0] r,
                                output logic [3:0] fo, output int lat);
    logic n, z, c, v;
    longint u, sl;
    int amt, ci;
    bit nz;
    n = fi[0]; z = fi[1]; c = fi[2]; v = fi[3];
    r = 32'h0; lat = 1; nz = 1; u = 0; sl = 0;
    amt = int'(b[4:0]);
    case (op)
      5'd1: r = a & b;
      5'd2: r = a | b;
      5'd3: r = ~a;
      5'd4: r = a ^ b;
      5'd5, 5'd6: begin
        ci = (op == 5'd5) ? int'(c) : 0;
        u  = longint'(a) + longint'(b) + longint'(ci);
        sl = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        r  = u[31:0];
        c  = (u >= 64'h1_0000_0000);
        v  = (sl != longint'($signed(r)));
      end
      5'd7, 5'd8, 5'd18: begin
        ci = (op == 5'd7) ? int'(c) : 1;
        u  = longint'(a) - longint'(b) - longint'(1 - ci);
        sl = longint'($signed(a)) - longint'($signed(b)) - longint'(1 - ci);
        r  = u[31:0];
        c  = (u >= 0);
        v  = (sl != longint'($signed(r)));
      end
      5'd9: begin r = a * b; lat = 33; end
      5'd10: begin r = a >> amt; if (amt != 0) c = a[amt-1]; end
      5'd11: begin r = a << amt; if (amt != 0) c = a[32-amt]; end
      5'd12: begin r = 32'($signed(a) >>> amt); if (amt != 0) c = a[amt-1]; end
      5'd13: begin
        r = (amt == 0) ? a : ((a >> amt) | (a << (32 - amt)));
        if (amt != 0) c = r[31];
      end
      5'd14: begin r = {24'h0, a[7:0]};          nz = 0; end
      5'd15: begin r = {16'h0, a[15:0]};         nz = 0; end
      5'd16: begin r = {{24{a[7]}}, a[7:0]};     nz = 0; end
      5'd17: begin r = {{16{a[15]}}, a[15:0]};   nz = 0; end
      5'd19, 5'd20: begin
        lat = 33;
        if (b == 0) begin r = (op == 5'd19) ? 32'hFFFF_FFFF : a; v = 1'b1; end
        else        begin r = (op == 5'd19) ? a / b : a % b;     v = 1'b0; end
      end
      default: begin r = 32'h0; nz = 0; end
    endcase
    if (nz) begin n = r[31]; z = (r == 0); end
    if (op == 5'd18) r = 32'h0;
    fo = {v, c, z, n};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input bit lit = 0, input logic [31:0] lr = 0, input logic [3:0] lf = 0);
    txn_t t;
    int waited;
    bit ok;
    waited = 0; ok = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    while (!ok && waited < 200) begin
      if (bus.in_ready === 1'b1) ok = 1;
      else begin @(negedge clk); #1; waited++; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: op %0d not accepted, in_ready %b, expected 1", op, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    model(op, a, b, mflags, t.r, t.f, t.lat);
    mflags = t.f;
    t.op = op; t.acc = cyc + 1; t.lit = lit; t.lr = lr; t.lf = lf;
    q.push_back(t);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom_range(31));
    bus.a  = 32'($urandom);
    bus.b  = 32'($urandom);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 2000) begin @(negedge clk); guard++; end
    n_cmp++;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    bit started, ev, eb;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        started = 0; ev = 0; eb = 0;
        if (q.size() > 0) begin
          started = (q[0].acc <= cyc);
          ev = started && (cyc - q[0].acc >= q[0].lat - 1);
          eb = started && !ev && (q[0].lat > 1);
        end
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        chk("busy", 64'(bus.busy), 64'(eb));
        if (ev) begin
          chk("result", 64'(bus.result), 64'(q[0].r));
          chk("flags", 64'(bus.flags), 64'(q[0].f));
          chk("in_ready_done", 64'(bus.in_ready), 64'(bus.out_ready));
          if (q[0].lit) begin
            chk("lit_result", 64'(bus.result), 64'(q[0].lr));
            chk("lit_flags", 64'(bus.flags), 64'(q[0].lf));
          end
          if (bus.out_ready) begin
            n_txn++;
            $display("txn %0d op=%0d result=%h flags=%b cycle=%0d", n_txn, q[0].op, bus.result, bus.flags, cyc);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mr;
    logic [3:0]  mf;
    int          ml;
    logic [4:0]  rop;
    bus.in_valid = 1'b0; bus.op = 5'd0; bus.a = 32'h0; bus.b = 32'h0; bus.out_ready = 1'b1;

    model(5'd6, 32'hFFFF_FFFF, 32'h1, 4'b0000, mr, mf, ml);
    chk("pin_adds_r", 64'(mr), 64'h0); chk("pin_adds_f", 64'(mf), 64'b0110);
    model(5'd8, 32'h0, 32'h1, 4'b0000, mr, mf, ml);
    chk("pin_sub_r", 64'(mr), 64'hFFFF_FFFF); chk("pin_sub_f", 64'(mf), 64'b0001);
    model(5'd18, 32'h5, 32'h5, 4'b0000, mr, mf, ml);
    chk("pin_cmp_r", 64'(mr), 64'h0); chk("pin_cmp_f", 64'(mf), 64'b0110);
    model(5'd12, 32'h8000_0000, 32'h4, 4'b0000, mr, mf, ml);
    chk("pin_asr_r", 64'(mr), 64'hF800_0000); chk("pin_asr_f", 64'(mf), 64'b0001);
    model(5'd9, 32'hFFFF_FFFD, 32'h7, 4'b0000, mr, mf, ml);
    chk("pin_muls_lat", 64'(ml), 64'd33);

    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_result", 64'(bus.result), 64'h0);
    chk("rst_flags", 64'(bus.flags), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    rst_n = 1'b1;

    send(5'd6,  32'hFFFF_FFFF, 32'h1, 1, 32'h0,         4'b0110);
    send(5'd6,  32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 4'b1001);
    send(5'd5,  32'h0,         32'h0, 1, 32'h0,         4'b0010);
    send(5'd9,  32'hFFFF_FFFD, 32'h7, 1, 32'hFFFF_FFEB, 4'b0001);
    send(5'd19, 32'd100,       32'd7, 1, 32'd14,        4'b0000);
    send(5'd20, 32'd100,       32'd7, 1, 32'd2,         4'b0000);
    send(5'd19, 32'd5,         32'd0, 1, 32'hFFFF_FFFF, 4'b1001);
    send(5'd20, 32'd5,         32'd0, 1, 32'd5,         4'b1000);
    send(5'd10, 32'd3,         32'd1, 1, 32'd1,         4'b1100);
    send(5'd10, 32'd4,         32'd0, 1, 32'd4,         4'b1100);
    send(5'd16, 32'h80,        32'h0, 1, 32'hFFFF_FF80, 4'b1100);
    drain();

    ready_mode = 2;
    send(5'd6, 32'd1, 32'd2, 1, 32'd3, 4'b0000);
    repeat (5) begin
      @(negedge clk); #3;
      chk("hold_valid", 64'(bus.out_valid), 64'h1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'h0);
      chk("hold_result", 64'(bus.result), 64'd3);
      chk("hold_flags", 64'(bus.flags), 64'b0000);
    end
    ready_mode = 0;
    drain();

    send(5'd19, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    #3;
    chk("pre_reset_busy", 64'(bus.busy), 64'h1);
    rst_n = 1'b0;
    q.delete();
    mflags = 4'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
    chk("mid_rst_result", 64'(bus.result), 64'h0);
    chk("mid_rst_flags", 64'(bus.flags), 64'h0);
    @(negedge clk); #3;
    rst_n = 1'b1;
    send(5'd6,  32'hFFFF_FFFF, 32'h1, 1, 32'h0,  4'b0110);
    send(5'd19, 32'd100,       32'd7, 1, 32'd14, 4'b0100);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 6) begin
        rop = ($urandom_range(11) == 0) ? 5'd0 : 5'($urandom_range(31, 21));
      end else begin
        rop = 5'($urandom_range(20, 1));
      end
      send(rop, pick_val(), pick_val());
      if ($urandom_range(3) == 0) repeat ($urandom_range(2)) @(negedge clk);
    end
    ready_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
